// File: rtl/dbus_uart_tx_if.sv
`default_nettype none
// ============================================================================
// dbus_uart_tx_if
// Data-bus signals shared by the core, the data memory and the UART window:
// write strobe, byte address, write data and read data.
// Revision: 1.0
// ============================================================================
interface dbus_uart_tx_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output WE, output A, output WD, input RD);
  modport slave  (input WE, input A, input WD, output RD);
endinterface
`default_nettype wire

// File: rtl/dbus_uart_tx.sv
`default_nettype none
// ============================================================================
// dbus_uart_tx
// Memory-mapped 8N1 UART transmitter: a small TX FIFO fed by bus stores and a
// baud-counted shift FSM. Registers: 0 TXDATA, 1 STATUS, 2 CTRL, 3 reserved.
// Revision: 1.0
// ============================================================================
module dbus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  dbus_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            enable;

  logic            hit;
  logic [1:0]      sel;
  logic            wr_txdata;
  logic            wr_status;
  logic            wr_ctrl;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            ovf_set;
  logic            baud_last;
  logic [3:0]      count4;

  // Upper write-data bits and the byte offset carry no meaning here.
  logic            unused_bits;
  assign unused_bits = ^{bus.WD[31:8], bus.A[1:0]};

  assign hit       = (bus.A[31:4] == BASE_ADDR[31:4]);
  assign sel       = bus.A[3:2];
  assign wr_txdata = bus.WE && hit && (sel == 2'd0);
  assign wr_status = bus.WE && hit && (sel == 2'd1);
  assign wr_ctrl   = bus.WE && hit && (sel == 2'd2);

  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign pop       = (state == IDLE) && enable && !empty;
  // A pop on the same edge frees a slot, so a push on a full FIFO still lands.
  assign push      = wr_txdata && (!full || pop);
  assign ovf_set   = wr_txdata && full && !pop;
  assign baud_last = (baud == BAUD_LAST);
  assign count4    = 4'(count);

  assign busy      = (state != IDLE) || !empty;

  // FIFO storage; no reset needed since entries are only read when counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.WD[7:0];
  end

  // FIFO pointers, occupancy, sticky overflow and the enable bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // An overflowing push beats a simultaneous write-1-to-clear.
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_status && bus.WD[3])
        overflow <= 1'b0;
      if (wr_ctrl) enable <= bus.WD[0];
    end
  end

  // Frame FSM; tx is registered from the current state, one cycle behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          tx <= shreg[bit_idx];
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_last) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational read mux; zero outside the window and for TXDATA/reserved.
  always_comb begin
    bus.RD = 32'h0;
    if (hit) begin
      case (sel)
        2'd1:    bus.RD = {24'h0, count4, overflow, empty, full, (state != IDLE)};
        2'd2:    bus.RD = {31'h0, enable};
        default: bus.RD = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_dbus_uart_tx
// Directed bench for dbus_uart_tx with CLKS_PER_BIT = 4.
// Revision: 1.0
// ============================================================================
module tb_dbus_uart_tx;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk;
  logic reset;
  logic tx;
  logic busy;

  int tests_run;
  int tests_failed;

  dbus_uart_tx_if bus ();

  dbus_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus store; takes effect on the next rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.WE = 1'b1;
    bus.A  = addr;
    bus.WD = data;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.A = addr;
    #1;
    check(tag, bus.RD, exp);
  endtask

  // Checks tx once per cycle for frame cycles first_k..39 (start, 8 data, stop).
  task automatic expect_frame(input logic [7:0] b, input int first_k);
    logic exp;
    int   idx;
    for (int k = first_k; k < 10 * CPB; k++) begin
      @(negedge clk);
      idx = k / CPB;
      if (idx == 0)      exp = 1'b0;
      else if (idx == 9) exp = 1'b1;
      else               exp = b[idx-1];
      check($sformatf("frame_%02h_k%0d", b, k), {31'h0, tx}, {31'h0, exp});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    bus.WE = 1'b0;
    bus.A  = 32'h0;
    bus.WD = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read("reset_status", BASE + 32'h4, 32'h4);
    bus_read("reset_ctrl", BASE + 32'h8, 32'h0);

    // Single byte 0xA5
    bus_write(BASE + 32'h8, 32'h1);
    bus_read("ctrl_enabled", BASE + 32'h8, 32'h1);
    bus_write(BASE + 32'h0, 32'hA5);
    @(negedge clk);
    check("lat_tx_n", {31'h0, tx}, 32'h1);
    check("lat_busy_n", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("lat_tx_n1", {31'h0, tx}, 32'h1);
    bus_read("status_in_flight", BASE + 32'h4, 32'h5);
    expect_frame(8'hA5, 0);
    @(negedge clk);
    check("single_done_tx", {31'h0, tx}, 32'h1);
    check("single_done_busy", {31'h0, busy}, 32'h0);

    // FIFO fill with enable low, overflow, clear, drain back to back
    bus_write(BASE + 32'h8, 32'h0);
    bus_write(BASE + 32'h0, 32'h11);
    bus_write(BASE + 32'h0, 32'h22);
    bus_write(BASE + 32'h0, 32'h33);
    bus_write(BASE + 32'h0, 32'h44);
    bus_write(BASE + 32'h0, 32'h55);
    bus_read("fill_status", BASE + 32'h4, 32'h4A);
    check("fill_busy", {31'h0, busy}, 32'h1);
    bus_write(BASE + 32'h4, 32'h8);
    bus_read("ovf_cleared", BASE + 32'h4, 32'h42);
    bus_write(BASE + 32'h8, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("drain_pre_tx", {31'h0, tx}, 32'h1);
    expect_frame(8'h11, 0);
    @(negedge clk); check("gap1", {31'h0, tx}, 32'h1);
    expect_frame(8'h22, 0);
    @(negedge clk); check("gap2", {31'h0, tx}, 32'h1);
    expect_frame(8'h33, 0);
    @(negedge clk); check("gap3", {31'h0, tx}, 32'h1);
    expect_frame(8'h44, 0);
    @(negedge clk);
    check("drain_done_busy", {31'h0, busy}, 32'h0);
    bus_read("drain_done_status", BASE + 32'h4, 32'h4);

    // Push on full at the pop edge
    bus_write(BASE + 32'h8, 32'h0);
    bus_write(BASE + 32'h0, 32'hC1);
    bus_write(BASE + 32'h0, 32'hC2);
    bus_write(BASE + 32'h0, 32'hC3);
    bus_write(BASE + 32'h0, 32'hC4);
    bus_read("full_status", BASE + 32'h4, 32'h42);
    bus_write(BASE + 32'h8, 32'h1);
    bus_write(BASE + 32'h0, 32'hC5);
    bus_read("push_pop_full", BASE + 32'h4, 32'h43);
    @(negedge clk);
    check("pp_pre_tx", {31'h0, tx}, 32'h1);
    expect_frame(8'hC1, 0);
    @(negedge clk); check("pp_gap2", {31'h0, tx}, 32'h1);
    expect_frame(8'hC2, 0);
    @(negedge clk); check("pp_gap3", {31'h0, tx}, 32'h1);
    expect_frame(8'hC3, 0);
    @(negedge clk); check("pp_gap4", {31'h0, tx}, 32'h1);
    expect_frame(8'hC4, 0);
    @(negedge clk); check("pp_gap5", {31'h0, tx}, 32'h1);
    expect_frame(8'hC5, 0);
    @(negedge clk);
    check("pp_done_busy", {31'h0, busy}, 32'h0);

    // Enable cleared mid-frame with two bytes queued
    bus_write(BASE + 32'h0, 32'hD1);
    bus_write(BASE + 32'h0, 32'hD2);
    bus_write(BASE + 32'h0, 32'hD3);
    bus_write(BASE + 32'h8, 32'h0);
    expect_frame(8'hD1, 1);
    for (int i = 0; i < 6; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("held_idle_%0d", i), {31'h0, tx}, 32'h1);
    end
    bus_read("held_status", BASE + 32'h4, 32'h20);
    check("held_busy", {31'h0, busy}, 32'h1);
    bus_write(BASE + 32'h8, 32'h1);
    @(negedge clk);
    @(negedge clk);
    expect_frame(8'hD2, 0);
    @(negedge clk); check("resume_gap", {31'h0, tx}, 32'h1);
    expect_frame(8'hD3, 0);
    @(negedge clk);
    check("resume_done_busy", {31'h0, busy}, 32'h0);

    // Decode: reserved and out-of-window accesses
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h18, 32'h0);
    bus.A  = BASE;
    bus.WD = 32'h55;
    @(posedge clk);
    #1;
    bus_read("rd_reserved", BASE + 32'hC, 32'h0);
    bus_read("rd_outside", BASE + 32'h10, 32'h0);
    bus_read("dec_status", BASE + 32'h4, 32'h4);
    bus_read("dec_ctrl", BASE + 32'h8, 32'h1);
    check("dec_busy", {31'h0, busy}, 32'h0);
    bus_write(BASE + 32'h8, 32'hFFFF_FFFE);
    bus_read("ctrl_upper_bits", BASE + 32'h8, 32'h0);
    bus_write(BASE + 32'h0, 32'h01);
    bus_write(BASE + 32'h0, 32'h02);
    bus_write(BASE + 32'h0, 32'h03);
    bus_write(BASE + 32'h0, 32'h04);
    bus_write(BASE + 32'h0, 32'h05);
    bus_read("ovf_again", BASE + 32'h4, 32'h4A);
    bus_write(BASE + 32'h4, 32'h0);
    bus_read("w0_no_clear", BASE + 32'h4, 32'h4A);
    bus_write(BASE + 32'h5, 32'h8);
    bus_read("alias_clear", BASE + 32'h4, 32'h42);

    // Reset during a start bit
    bus_write(BASE + 32'h8, 32'hFFFF_FFFF);
    bus_read("ctrl_all_ones", BASE + 32'h8, 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_start", {31'h0, tx}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, tx}, 32'h1);
    check("async_reset_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read("post_reset_status", BASE + 32'h4, 32'h4);
    bus_read("post_reset_ctrl", BASE + 32'h8, 32'h0);
    check("post_reset_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("post_reset_tx", {31'h0, tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbus_uart_tx.md
# dbus_uart_tx

Memory-mapped UART transmitter that responds to the core's data-bus stores and loads, sitting beside the data memory on the same `WE`/`A`/`WD`/`RD` bus. The core writes bytes into a small TX FIFO; a baud counter and shift FSM serialise them as 8N1 frames on `tx`. The top-level read mux selects `RD` from this block when the address falls in its window.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: 16-byte aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, at least 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries, a power of two.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `WE` input 1: bus write strobe, same as the data-memory `WE`.
- `A` input 32: byte address, same as the data-memory `A`.
- `WD` input 32: write data.
- `RD` output 32: combinational read data. It is 0 when `A` is outside the window.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high while a frame is in flight or the FIFO is non-empty.

## Operation
- Decode: the window is hit when `A[31:4] == BASE_ADDR[31:4]`. `A[3:2]` selects the register. `A[1:0]` is ignored.
- Register 0, TXDATA: a write pushes `WD[7:0]`. A read returns 0.
- Register 1, STATUS (read-only except bit 3):
  - bit0: frame in flight.
  - bit1: FIFO full.
  - bit2: FIFO empty.
  - bit3: sticky overflow. Write 1 to clear.
  - bits[7:4]: FIFO count.
  - All other bits read 0.
- Register 2, CTRL: bit0 is `enable`, read/write. Other bits read 0 and are not writable.
- Register 3: reserved. Reads return 0 and writes are ignored.
- Writes take effect on the `clk` edge where `WE` is 1 and the address hits. Writes with `WE` low or outside the window are ignored.
- Push when full: the byte is dropped and overflow is set.
- Push and pop in the same cycle on a full FIFO: the push is accepted and the count is unchanged.
- FSM states:
  - IDLE: `tx`=1. If `enable` is 1 and the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Counters: the baud counter runs 0 to `CLKS_PER_BIT-1` and wraps. The bit index runs 0 to 7.
- Clearing `enable` mid-frame: the current frame completes and no further pop occurs.
- Write-1-to-clear of overflow in the same cycle as an overflowing push: set wins, so overflow stays 1.
- The FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `clog2(FIFO_DEPTH)+1` bits wide.

## Timing
- Reset values (reset low, asynchronous):
  - `tx`=1, `busy`=0.
  - FIFO empty, overflow=0, `enable`=0.
  - FSM in IDLE, counters at 0.
  - `RD` at STATUS reads 32'h0000_0004.
- Reset asserted mid-frame: `tx` returns to 1 immediately and all queued data is discarded.
- Latency, with `enable` set:
  - Write edge N.
  - FSM pops at edge N+1.
  - `tx` falls after edge N+2.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from the start-bit edge to the end of the stop bit.
- Back-to-back frames: exactly one IDLE cycle (`tx`=1) separates consecutive frames.
- `busy` changes on the same edges as the internal state, with no extra delay.
- `RD` is purely combinational from `A` and the current register state. A read in the same cycle as a write returns the pre-write value.

## Test plan
- Reset: drive reset low mid-frame → `tx`=1 at once. After release, STATUS reads 0x4 and `busy`=0.
- Single byte, `CLKS_PER_BIT`=4: write CTRL=1, then TXDATA=0xA5 → `tx` shows start 0, bits 1,0,1,0,0,1,0,1, then stop 1, each held 4 cycles, 40 cycles total.
- FIFO fill with `enable`=0: write 5 bytes → STATUS shows count=4, full=1, overflow=1. Writing STATUS=0x8 clears overflow. Setting `enable` sends 4 frames, with 1 idle cycle between each.
- Push on full while popping: the FIFO is full when `enable` rises and a write lands on the pop edge → the byte is accepted, count stays 4, overflow stays 0.
- `enable` cleared mid-frame with 2 bytes queued → the current frame finishes and `tx` stays 1 afterwards. Count=2 and `busy`=1 until re-enabled.
- Decode: reads at BASE+0xC and at BASE+0x10 return 0. Writes there change no state. A write to BASE+0x5 acts as a write to STATUS.
